instr_assembler: RTL and testbench

Sequential instruction assembler: the encode-side counterpart of the FRiscV instruction decoder. Accepts decoded field tuples (opcode, func3, func7, rs1, rs2, rd, immediate) over a valid/ready handshake. Packs each tuple into an RV32I instruction word per its format and writes the word into instruction memory through a single write port at consecutive word addresses. Used by the testbench and the boot loader to build program images without hand-encoded hex.

---
 rtl/friscv_pkg.sv | 27 ++
 rtl/instr_encode.sv | 58 +++++
 rtl/instr_assembler.sv | 146 ++++++++++++++
 tb/tb_instr_assembler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/friscv_pkg.sv
// friscv_pkg: shared architecture constants for the FRiscV encode/decode
// blocks. Holds the datapath width, register file depth, the RV32I major
// opcodes understood by the assembler, and the assembler FSM state type.
package friscv_pkg;

  localparam int ARCH          = 32;
  localparam int REGFILE_DEPTH = 32;
  localparam int REG_W         = $clog2(REGFILE_DEPTH);

  // RV32I major opcodes
  localparam logic [6:0] REG       = 7'b0110011;  // R-type ALU
  localparam logic [6:0] IMM_ARITH = 7'b0010011;  // I-type ALU
  localparam logic [6:0] IMM_JUMP  = 7'b1100111;  // JALR
  localparam logic [6:0] IMM_LOAD  = 7'b0000011;  // loads
  localparam logic [6:0] STORE     = 7'b0100011;  // stores
  localparam logic [6:0] BRANCH    = 7'b1100011;  // conditional branches
  localparam logic [6:0] U_L_LOAD  = 7'b0110111;  // LUI
  localparam logic [6:0] JUMP      = 7'b1101111;  // JAL

  typedef enum logic [1:0] {
    ASM_IDLE  = 2'd0,
    ASM_LOAD  = 2'd1,
    ASM_DONE  = 2'd2,
    ASM_ERROR = 2'd3
  } asm_state_t;

endpackage

// File: rtl/instr_encode.sv
// instr_encode: purely combinational RV32I field packer.
// Ports:
//   op_code, func3, func7, rs1, rs2, rd, imm : decoded instruction fields
//   word  : packed 32-bit instruction (zero when illegal)
//   legal : opcode is one of the supported major opcodes
// Fields not used by a format are ignored; immediate bits outside the
// format (including bit 0 of branch/jump offsets) are dropped.
module instr_encode
  import friscv_pkg::*;
(
  input  logic [6:0]       op_code,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  input  logic [ARCH-1:0]  imm,
  output logic [ARCH-1:0]  word,
  output logic             legal
);

  // Select the bit layout from the major opcode
  always_comb begin
    word  = {ARCH{1'b0}};
    legal = 1'b0;
    case (op_code)
      REG: begin
        word  = {func7, rs2, rs1, func3, rd, op_code};
        legal = 1'b1;
      end
      IMM_ARITH, IMM_JUMP, IMM_LOAD: begin
        word  = {imm[11:0], rs1, func3, rd, op_code};
        legal = 1'b1;
      end
      STORE: begin
        word  = {imm[11:5], rs2, rs1, func3, imm[4:0], op_code};
        legal = 1'b1;
      end
      BRANCH: begin
        word  = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], op_code};
        legal = 1'b1;
      end
      U_L_LOAD: begin
        word  = {imm[31:12], rd, op_code};
        legal = 1'b1;
      end
      JUMP: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op_code};
        legal = 1'b1;
      end
      default: begin
        word  = {ARCH{1'b0}};
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_assembler.sv
// instr_assembler: accepts decoded field tuples over valid/ready, packs
// each into an RV32I word and writes it to instruction memory at
// consecutive word addresses starting from a per-session base address.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start_in            : open a session (honoured in IDLE/DONE/ERROR)
//   base_addr_in        : byte address of the first word (low 2 bits cleared)
//   valid_in, last_in   : tuple valid, tuple closes the session
//   ready_out           : high while loading; tuple taken on valid&ready
//   op_code_in .. imm_in: instruction fields
//   wr_en_out/addr/data : single IMEM write port, one cycle per word
//   busy/done/error_out : LOAD / DONE / ERROR state flags
//   count_out           : words written in the current session
module instr_assembler
  import friscv_pkg::*;
#(
  parameter int IMEM_DEPTH = 256
)
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_in,
  input  logic [ARCH-1:0]               base_addr_in,
  input  logic                          valid_in,
  input  logic                          last_in,
  output logic                          ready_out,
  input  logic [6:0]                    op_code_in,
  input  logic [2:0]                    func3_in,
  input  logic [6:0]                    func7_in,
  input  logic [REG_W-1:0]              rs1_in,
  input  logic [REG_W-1:0]              rs2_in,
  input  logic [REG_W-1:0]              rd_in,
  input  logic [ARCH-1:0]               imm_in,
  output logic                          wr_en_out,
  output logic [ARCH-1:0]               wr_addr_out,
  output logic [ARCH-1:0]               wr_data_out,
  output logic                          busy_out,
  output logic                          done_out,
  output logic                          error_out,
  output logic [$clog2(IMEM_DEPTH):0]   count_out
);

  localparam int              CW         = $clog2(IMEM_DEPTH) + 1;
  localparam logic [CW-1:0]   COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   COUNT_FULL = CW'(IMEM_DEPTH);
  localparam logic [ARCH-1:0] ADDR_STEP  = ARCH'(4);
  localparam logic [ARCH-1:0] ADDR_MASK  = ~ARCH'(3);

  asm_state_t      state;
  logic [ARCH-1:0] ptr;
  logic [ARCH-1:0] enc_word;
  logic            enc_legal;
  logic            accept;
  logic [CW-1:0]   count_next;

  // ready_out is a registered copy of (state == LOAD), so it doubles as
  // the handshake qualifier without a combinational path from state.
  assign accept     = valid_in && ready_out;
  assign count_next = count_out + COUNT_ONE;

  instr_encode u_encode (
    .op_code (op_code_in),
    .func3   (func3_in),
    .func7   (func7_in),
    .rs1     (rs1_in),
    .rs2     (rs2_in),
    .rd      (rd_in),
    .imm     (imm_in),
    .word    (enc_word),
    .legal   (enc_legal)
  );

  // Session FSM, address pointer, word count and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ASM_IDLE;
      ptr         <= {ARCH{1'b0}};
      ready_out   <= 1'b0;
      wr_en_out   <= 1'b0;
      wr_addr_out <= {ARCH{1'b0}};
      wr_data_out <= {ARCH{1'b0}};
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
      error_out   <= 1'b0;
      count_out   <= {CW{1'b0}};
    end else begin
      wr_en_out <= 1'b0;
      case (state)
        ASM_IDLE, ASM_DONE, ASM_ERROR: begin
          if (start_in) begin
            state     <= ASM_LOAD;
            ptr       <= base_addr_in & ADDR_MASK;
            count_out <= {CW{1'b0}};
            ready_out <= 1'b1;
            busy_out  <= 1'b1;
            done_out  <= 1'b0;
            error_out <= 1'b0;
          end else begin
            state <= state;
          end
        end
        ASM_LOAD: begin
          if (accept) begin
            if (!enc_legal) begin
              // Illegal opcode: consume the tuple, write nothing
              state     <= ASM_ERROR;
              ready_out <= 1'b0;
              busy_out  <= 1'b0;
              error_out <= 1'b1;
            end else begin
              wr_en_out   <= 1'b1;
              wr_addr_out <= ptr;
              wr_data_out <= enc_word;
              ptr         <= ptr + ADDR_STEP;
              count_out   <= count_next;
              if (last_in) begin
                state     <= ASM_DONE;
                ready_out <= 1'b0;
                busy_out  <= 1'b0;
                done_out  <= 1'b1;
              end else if (count_next == COUNT_FULL) begin
                // Image is full but the session was not closed: overflow
                state     <= ASM_ERROR;
                ready_out <= 1'b0;
                busy_out  <= 1'b0;
                error_out <= 1'b1;
              end else begin
                state <= ASM_LOAD;
              end
            end
          end else begin
            state <= ASM_LOAD;
          end
        end
        default: begin
          state     <= ASM_IDLE;
          ready_out <= 1'b0;
          busy_out  <= 1'b0;
          done_out  <= 1'b0;
          error_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_assembler.sv
// Bench for instr_assembler. Two instances (IMEM_DEPTH 256 and 4) see the
// same stimulus; a session-level reference model per instance predicts
// writes (queued) and status flags, and a negedge monitor compares them.
module tb_instr_assembler;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_DONE = 2;
  localparam int S_ERR  = 3;

  logic        clk = 1'b0;
  logic        rst, start_in, valid_in, last_in;
  logic [31:0] base_addr_in, imm_in;
  logic [6:0]  op_code_in, func7_in;
  logic [2:0]  func3_in;
  logic [4:0]  rs1_in, rs2_in, rd_in;

  logic        ready0, wr_en0, busy0, done0, error0;
  logic [31:0] wr_addr0, wr_data0;
  logic [8:0]  count0;
  logic        ready1, wr_en1, busy1, done1, error1;
  logic [31:0] wr_addr1, wr_data1;
  logic [2:0]  count1;

  int checks = 0;
  int errors = 0;

  int          m_st [2];
  logic [31:0] m_ptr[2];
  int          m_cnt[2];
  bit          m_wr [2];
  int          depth[2] = '{256, 4};
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  always #5 clk = ~clk;

  instr_assembler #(.IMEM_DEPTH(256)) u_dut (
    .clk(clk), .rst(rst), .start_in(start_in), .base_addr_in(base_addr_in),
    .valid_in(valid_in), .last_in(last_in), .ready_out(ready0),
    .op_code_in(op_code_in), .func3_in(func3_in), .func7_in(func7_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .imm_in(imm_in),
    .wr_en_out(wr_en0), .wr_addr_out(wr_addr0), .wr_data_out(wr_data0),
    .busy_out(busy0), .done_out(done0), .error_out(error0), .count_out(count0)
  );

  instr_assembler #(.IMEM_DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .start_in(start_in), .base_addr_in(base_addr_in),
    .valid_in(valid_in), .last_in(last_in), .ready_out(ready1),
    .op_code_in(op_code_in), .func3_in(func3_in), .func7_in(func7_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .imm_in(imm_in),
    .wr_en_out(wr_en1), .wr_addr_out(wr_addr1), .wr_data_out(wr_data1),
    .busy_out(busy1), .done_out(done1), .error_out(error1), .count_out(count1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: {legal, word}, built with shifts and masks
  function automatic logic [32:0] ref_encode(input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] s1, input logic [4:0] s2,
      input logic [4:0] d, input logic [31:0] i);
    logic [31:0] o, a3, a7, r1, r2, rdw, w;
    logic        ok;
    o = {25'd0, op}; a3 = {29'd0, f3}; a7 = {25'd0, f7};
    r1 = {27'd0, s1}; r2 = {27'd0, s2}; rdw = {27'd0, d};
    ok = 1'b1;
    w  = 32'd0;
    case (op)
      7'h33: w = (a7 << 25) | (r2 << 20) | (r1 << 15) | (a3 << 12) | (rdw << 7) | o;
      7'h13, 7'h67, 7'h03:
             w = ((i & 32'hFFF) << 20) | (r1 << 15) | (a3 << 12) | (rdw << 7) | o;
      7'h23: w = (((i >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (a3 << 12)
               | ((i & 32'h1F) << 7) | o;
      7'h63: w = (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25) | (r2 << 20)
               | (r1 << 15) | (a3 << 12) | (((i >> 1) & 32'hF) << 8)
               | (((i >> 11) & 32'h1) << 7) | o;
      7'h37: w = (i & 32'hFFFFF000) | (rdw << 7) | o;
      7'h6F: w = (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3FF) << 21)
               | (((i >> 11) & 32'h1) << 20) | (((i >> 12) & 32'hFF) << 12) | (rdw << 7) | o;
      default: ok = 1'b0;
    endcase
    return {ok, w};
  endfunction

  // Advance both models by one clock edge using the current inputs
  task automatic model_step();
    logic [32:0] e;
    for (int d = 0; d < 2; d++) begin
      m_wr[d] = 1'b0;
      if (rst) begin
        m_st[d] = S_IDLE; m_cnt[d] = 0; m_ptr[d] = 32'd0;
      end else if (m_st[d] != S_LOAD) begin
        if (start_in) begin
          m_st[d] = S_LOAD; m_cnt[d] = 0; m_ptr[d] = base_addr_in & 32'hFFFFFFFC;
        end
      end else if (valid_in) begin
        e = ref_encode(op_code_in, func3_in, func7_in, rs1_in, rs2_in, rd_in, imm_in);
        if (!e[32]) begin
          m_st[d] = S_ERR;
        end else begin
          if (d == 0) q0.push_back({m_ptr[d], e[31:0]});
          else        q1.push_back({m_ptr[d], e[31:0]});
          m_wr[d]  = 1'b1;
          m_ptr[d] = m_ptr[d] + 32'd4;
          m_cnt[d] = m_cnt[d] + 1;
          if (last_in)                  m_st[d] = S_DONE;
          else if (m_cnt[d] == depth[d]) m_st[d] = S_ERR;
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_dut(input int d, input logic wr_en, input logic [31:0] addr,
      input logic [31:0] data, input logic rdy, input logic bsy, input logic dn,
      input logic er, input int cnt);
    logic [63:0] exp;
    chk($sformatf("d%0d_wr_en", d), {63'd0, wr_en}, {63'd0, m_wr[d]});
    chk($sformatf("d%0d_ready", d), {63'd0, rdy}, {63'd0, m_st[d] == S_LOAD});
    chk($sformatf("d%0d_busy", d),  {63'd0, bsy}, {63'd0, m_st[d] == S_LOAD});
    chk($sformatf("d%0d_done", d),  {63'd0, dn},  {63'd0, m_st[d] == S_DONE});
    chk($sformatf("d%0d_error", d), {63'd0, er},  {63'd0, m_st[d] == S_ERR});
    chk($sformatf("d%0d_count", d), 64'(cnt), 64'(m_cnt[d]));
    if (wr_en === 1'b1) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        checks++; errors++;
        $display("FAIL d%0d_unexpected_write: got addr 0x%0h data 0x%0h expected none", d, addr, data);
      end else begin
        exp = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("d%0d_wr_addr", d), {32'd0, addr}, {32'd0, exp[63:32]});
        chk($sformatf("d%0d_wr_data", d), {32'd0, data}, {32'd0, exp[31:0]});
      end
    end
  endtask

  // Monitor: compare both instances against the models every cycle
  always @(negedge clk) begin
    check_dut(0, wr_en0, wr_addr0, wr_data0, ready0, busy0, done0, error0, int'(count0));
    check_dut(1, wr_en1, wr_addr1, wr_data1, ready1, busy1, done1, error1, int'(count1));
  end

  task automatic tuple(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
      input logic [31:0] i, input logic lst);
    valid_in = 1'b1; last_in = lst; op_code_in = op; func3_in = f3; func7_in = f7;
    rs1_in = s1; rs2_in = s2; rd_in = d; imm_in = i;
    step();
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic start(input logic [31:0] base);
    start_in = 1'b1; base_addr_in = base;
    step();
    start_in = 1'b0;
  endtask

  task automatic rand_tuple(input logic lst);
    logic [6:0] legal_ops [8];
    legal_ops = '{7'h33, 7'h13, 7'h67, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F};
    tuple(legal_ops[$urandom_range(0, 7)], 3'($urandom), 7'($urandom), 5'($urandom),
          5'($urandom), 5'($urandom), $urandom, lst);
  endtask

  initial begin
    logic [6:0] legal_ops [8];
    legal_ops = '{7'h33, 7'h13, 7'h67, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F};
    rst = 1'b1; start_in = 1'b0; valid_in = 1'b0; last_in = 1'b0;
    base_addr_in = 32'd0; imm_in = 32'd0; op_code_in = 7'd0;
    func3_in = 3'd0; func7_in = 7'd0; rs1_in = 5'd0; rs2_in = 5'd0; rd_in = 5'd0;
    step(); step();
    rst = 1'b0;
    chk("reset_wr_addr", {32'd0, wr_addr0}, 64'd0);
    chk("reset_wr_data", {32'd0, wr_data0}, 64'd0);
    step();

    // ADD, then an illegal opcode mid-stream
    start(32'h0000_0100);
    tuple(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    tuple(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd4, 32'd1, 1'b0);
    tuple(7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    step();

    // Back-to-back stream closed by last_in (small instance overflows on LUI)
    start(32'h0000_0102);
    tuple(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b0);
    tuple(7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8, 1'b0);
    tuple(7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, 1'b0);
    tuple(7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 1'b0);
    tuple(7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd8, 1'b1);
    step();

    // Address wrap and small-instance overflow after 4 writes
    start(32'hFFFF_FFFC);
    for (int k = 0; k < 4; k++) rand_tuple(1'b0);
    rand_tuple(1'b1);
    step();

    // Reset the cycle after an acceptance drops the session
    start(32'h0000_0200);
    rand_tuple(1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_wr_addr", {32'd0, wr_addr0}, 64'd0);
    chk("midrst_wr_data", {32'd0, wr_data0}, 64'd0);
    rand_tuple(1'b0);
    step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 199) == 0);
      start_in     = ($urandom_range(0, 19) == 0);
      base_addr_in = $urandom;
      valid_in     = ($urandom_range(0, 9) < 7);
      last_in      = ($urandom_range(0, 11) == 0);
      op_code_in   = ($urandom_range(0, 19) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 7)];
      func3_in = 3'($urandom); func7_in = 7'($urandom);
      rs1_in = 5'($urandom); rs2_in = 5'($urandom); rd_in = 5'($urandom);
      imm_in = $urandom;
      step();
    end
    rst = 1'b0; start_in = 1'b0; valid_in = 1'b0; last_in = 1'b0;
    step(); step();

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
